// File: rtl/drum_pkg.sv
// Shared types and helpers for the drum column solver and its node ALU.
package drum_pkg;

  localparam int DRUM_WIDTH = 18;
  localparam int DRUM_FRAC  = 17;

  typedef logic signed [DRUM_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_WRAP,
    S_DONE
  } state_e;

  // Symmetric clamp to +/-(2^(w-1)-1) so the most negative code never appears.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/drum_node_alu.sv
// One node update: 5-point Laplacian, tension scaling, leapfrog step, damping, saturation.
module drum_node_alu
  import drum_pkg::*;
#(
  parameter int WIDTH     = DRUM_WIDTH,
  parameter int FRAC      = DRUM_FRAC,
  parameter int ETA_SHIFT = 10
) (
  input  logic signed [WIDTH-1:0] up,
  input  logic signed [WIDTH-1:0] down,
  input  logic signed [WIDTH-1:0] left,
  input  logic signed [WIDTH-1:0] right,
  input  logic signed [WIDTH-1:0] u,
  input  logic signed [WIDTH-1:0] u_prev,
  input  logic signed [WIDTH-1:0] rho,
  output logic signed [WIDTH-1:0] u_next
);

  localparam int LW = WIDTH + 3;
  localparam int PW = WIDTH + LW;

  logic signed [LW-1:0] lap;
  logic signed [PW-1:0] prod;
  logic signed [63:0]   tmp;
  logic signed [63:0]   damped;

  always_comb begin
    lap    = LW'(up) + LW'(down) + LW'(left) + LW'(right) - (LW'(u) <<< 2);
    prod   = PW'(rho) * PW'(lap);
    tmp    = 64'(prod >>> FRAC) + (64'(u) <<< 1) - 64'(u_prev) + 64'(u_prev >>> ETA_SHIFT);
    damped = tmp - (tmp >>> ETA_SHIFT);
    u_next = WIDTH'(sat(damped, WIDTH));
  end

endmodule

// File: rtl/drum_column_solver.sv
// One tileable drum column: ping-pong u(n)/u(n-1) banks, one row per cycle, sliding row window.
module drum_column_solver
  import drum_pkg::*;
#(
  parameter int ROWS      = 32,
  parameter int WIDTH     = DRUM_WIDTH,
  parameter int FRAC      = DRUM_FRAC,
  parameter int ETA_SHIFT = 10,
  parameter int TAP_ROW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              max_iterations,
  input  logic signed [WIDTH-1:0]  rho,
  input  logic                     init_we,
  input  logic [$clog2(ROWS)-1:0]  init_row,
  input  logic signed [WIDTH-1:0]  init_u,
  input  logic signed [WIDTH-1:0]  nbr_left,
  input  logic signed [WIDTH-1:0]  nbr_right,
  output logic [$clog2(ROWS)-1:0]  row_out,
  output logic signed [WIDTH-1:0]  u_out,
  output logic signed [WIDTH-1:0]  tap_out,
  output logic                     tap_valid,
  output logic [31:0]              iterations,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] TAP_R = RW'(TAP_ROW);

  state_e state, state_nxt;
  logic   idle_like, start_ok, init_ok, cmp_en, sel;
  logic [RW-1:0] cnt, cmp_row;
  logic [31:0]   max_r;
  logic signed [WIDTH-1:0] rho_r, q0, q1, cur_q, prv_q;
  logic signed [WIDTH-1:0] win_prev, win_cur, nl_r, nr_r, up_r, up_in, dn_in, u_next;
  logic signed [WIDTH-1:0] mem0 [ROWS];
  logic signed [WIDTH-1:0] mem1 [ROWS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_PRIME;
      S_PRIME:        state_nxt = (max_r == '0) ? S_DONE : S_RUN;
      S_RUN:          if (cnt == LAST) state_nxt = S_WRAP;
      S_WRAP:         state_nxt = (iterations + 32'd1 < max_r) ? S_PRIME : S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    idle_like = 1'b0;
    cmp_en    = 1'b0;
    case (state)
      S_IDLE:  idle_like = 1'b1;
      S_PRIME: busy = 1'b1;
      S_RUN:   begin busy = 1'b1; cmp_en = (cnt != '0); end
      S_WRAP:  begin busy = 1'b1; cmp_en = 1'b1; end
      S_DONE:  begin done = 1'b1; idle_like = 1'b1; end
      default: ;
    endcase
  end

  assign start_ok = idle_like & start;
  assign init_ok  = idle_like & init_we;

  // Row r is finished one cycle after row r+1 lands; the last row finishes in WRAP.
  assign cmp_row = (state == S_WRAP) ? LAST : cnt - RW'(1);
  assign cur_q   = sel ? q1 : q0;
  assign prv_q   = sel ? q0 : q1;
  assign u_out   = cur_q;
  assign up_in   = (cmp_row == '0)  ? '0 : win_prev;
  assign dn_in   = (cmp_row == LAST) ? '0 : cur_q;

  drum_node_alu #(
    .WIDTH     (WIDTH),
    .FRAC      (FRAC),
    .ETA_SHIFT (ETA_SHIFT)
  ) u_alu (
    .up     (up_in),
    .down   (dn_in),
    .left   (nl_r),
    .right  (nr_r),
    .u      (win_cur),
    .u_prev (up_r),
    .rho    (rho_r),
    .u_next (u_next)
  );

  // u_next overwrites u(n-1) at a row whose old value was already consumed.
  always_ff @(posedge clk) begin
    if (init_ok) begin
      mem0[init_row] <= init_u;
      mem1[init_row] <= init_u;
    end else if (cmp_en && sel) begin
      mem0[cmp_row] <= u_next;
    end else if (cmp_en) begin
      mem1[cmp_row] <= u_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_out    <= '0;
      q0         <= '0;
      q1         <= '0;
      tap_out    <= '0;
      tap_valid  <= 1'b0;
      iterations <= '0;
      cnt        <= '0;
      sel        <= 1'b0;
      max_r      <= '0;
      rho_r      <= '0;
      win_prev   <= '0;
      win_cur    <= '0;
      nl_r       <= '0;
      nr_r       <= '0;
      up_r       <= '0;
    end else begin
      q0        <= mem0[row_out];
      q1        <= mem1[row_out];
      tap_valid <= 1'b0;
      if (start_ok) begin
        max_r      <= max_iterations;
        rho_r      <= rho;
        iterations <= '0;
      end
      case (state)
        S_PRIME: begin
          row_out <= (max_r == '0) ? '0 : RW'(1);
          cnt     <= '0;
        end
        S_RUN: begin
          cnt      <= cnt + RW'(1);
          row_out  <= (row_out == LAST || row_out == '0) ? '0 : row_out + RW'(1);
          win_prev <= win_cur;
          win_cur  <= cur_q;
          nl_r     <= nbr_left;
          nr_r     <= nbr_right;
          up_r     <= prv_q;
        end
        S_WRAP: begin
          sel        <= ~sel;
          iterations <= iterations + 32'd1;
          row_out    <= '0;
        end
        default: row_out <= '0;
      endcase
      if (cmp_en && cmp_row == TAP_R) begin
        tap_out   <= u_next;
        tap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_drum_column_solver.sv
// Randomised bench for drum_column_solver against a plain-arithmetic wave-equation model.
module tb_drum_column_solver;
  import drum_pkg::*;

  localparam int ROWS = 8, W = DRUM_WIDTH, FRAC = DRUM_FRAC, ETA = 10, TAP = 4;
  localparam int STEP = ROWS + 2;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, init_we = 1'b0;
  logic [31:0] max_iterations = '0;
  sample_t     rho = '0, init_u = '0, nbr_left = '0, nbr_right = '0;
  logic [2:0]  init_row = '0, row_out;
  sample_t     u_out, tap_out;
  logic        tap_valid, busy, done;
  logic [31:0] iterations;

  drum_column_solver #(
    .ROWS(ROWS), .WIDTH(W), .FRAC(FRAC), .ETA_SHIFT(ETA), .TAP_ROW(TAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .max_iterations(max_iterations), .rho(rho),
    .init_we(init_we), .init_row(init_row), .init_u(init_u),
    .nbr_left(nbr_left), .nbr_right(nbr_right),
    .row_out(row_out), .u_out(u_out), .tap_out(tap_out), .tap_valid(tap_valid),
    .iterations(iterations), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  longint mu[ROWS], mp[ROWS], nl[ROWS], nr[ROWS], init_v[ROWS];
  longint snap[16][ROWS];
  longint exp_tap[16];
  logic [2:0] nb_row;

  // Static neighbour columns answer the row fetched in the previous cycle.
  always @(posedge clk) begin
    nb_row = row_out;
    #1;
    nbr_left  = sample_t'(nl[nb_row]);
    nbr_right = sample_t'(nr[nb_row]);
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint rnd_val();
    return longint'($urandom_range(0, 2 * 131071)) - MAXV;
  endfunction

  task automatic model_step(input longint rv);
    longint nx[ROWS];
    longint up, dn, lap, tmp, v;
    for (int r = 0; r < ROWS; r++) begin
      up  = (r == 0) ? 0 : mu[r-1];
      dn  = (r == ROWS - 1) ? 0 : mu[r+1];
      lap = up + dn + nl[r] + nr[r] - 4 * mu[r];
      tmp = ((rv * lap) >>> FRAC) + 2 * mu[r] - mp[r] + (mp[r] >>> ETA);
      v   = tmp - (tmp >>> ETA);
      if (v > MAXV) v = MAXV;
      if (v < -MAXV) v = -MAXV;
      nx[r] = v;
    end
    mp = mu;
    mu = nx;
  endtask

  // dist_k / rst_k: sample index at which to inject a stray start+init_we or an async reset (0 = none).
  task automatic run(input string tag, input int n, input longint rv, input bit do_load,
                     input int dist_k, input int rst_k);
    int k, ntap, done_k, s, off;
    max_iterations = n;
    rho = sample_t'(rv);
    if (do_load) begin
      for (int r = 0; r < ROWS; r++) begin
        init_we  = 1'b1;
        init_row = 3'(r);
        init_u   = sample_t'(init_v[r]);
        if (r == ROWS - 1) start = 1'b1;
        else tick();
      end
      mu = init_v;
      mp = init_v;
    end else begin
      start = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      snap[i] = mu;
      model_step(rv);
      exp_tap[i] = mu[TAP];
    end
    k = 0; ntap = 0; done_k = -1;
    while (k < n * STEP + 10) begin
      tick();
      k++;
      start = 1'b0;
      init_we = 1'b0;
      if (k == rst_k) begin
        rst = 1'b0;
        #1;
        check({tag, " busy@rst"}, busy, 0);
        tick();
        check({tag, " iter@rst"}, iterations, 0);
        check({tag, " row_out@rst"}, row_out, 0);
        check({tag, " tap_out@rst"}, tap_out, 0);
        check({tag, " tap_valid@rst"}, tap_valid, 0);
        check({tag, " done@rst"}, done, 0);
        rst = 1'b1;
        tick();
        return;
      end
      if (k == dist_k) begin
        start    = 1'b1;
        init_we  = 1'b1;
        init_row = 3'($urandom);
        init_u   = sample_t'(rnd_val());
      end
      s = (k - 1) / STEP;
      off = (k - 1) % STEP;
      if (s < n) begin
        if (off < ROWS) check($sformatf("%s row_out s%0d", tag, s), row_out, off);
        if (off >= 1 && off <= ROWS)
          check($sformatf("%s u_out s%0d r%0d", tag, s, off - 1), u_out, snap[s][off-1]);
      end
      if (tap_valid) begin
        if (ntap < n) check($sformatf("%s tap s%0d", tag, ntap), tap_out, exp_tap[ntap]);
        else check({tag, " spurious tap_valid"}, tap_valid, 0);
        ntap++;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    check({tag, " done cycle"}, done_k, (n == 0) ? 2 : n * STEP + 1);
    check({tag, " iterations"}, iterations, n);
    check({tag, " tap count"}, ntap, n);
    check({tag, " busy in done"}, busy, 0);
  endtask

  task automatic set_all(input longint v, input longint nbv);
    for (int r = 0; r < ROWS; r++) begin
      init_v[r] = v;
      nl[r] = nbv;
      nr[r] = nbv;
    end
  endtask

  task automatic set_random(input bit edge_col);
    for (int r = 0; r < ROWS; r++) begin
      init_v[r] = rnd_val();
      nl[r] = rnd_val();
      nr[r] = edge_col ? 0 : rnd_val();
    end
  endtask

  initial begin
    longint rv;
    set_all(0, 0);
    repeat (2) tick();
    check("reset row_out", row_out, 0);
    check("reset u_out", u_out, 0);
    check("reset tap_out", tap_out, 0);
    check("reset tap_valid", tap_valid, 0);
    check("reset iterations", iterations, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b1;
    tick();

    set_all(0, 0);
    run("zero", 5, 16384, 1'b1, 0, 0);

    set_all(0, 0);
    init_v[4] = 65536;
    run("impulse", 1, 32768, 1'b1, 0, 0);
    run("impulse_cont", 2, 32768, 1'b0, 0, 0);

    set_all(129761, 129761);
    run("p99", 3, 65536, 1'b1, 0, 0);

    set_all(MAXV, MAXV);
    run("sat_pos", 2, -131072, 1'b1, 0, 0);
    set_all(-MAXV, -MAXV);
    run("sat_neg", 2, -131072, 1'b1, 0, 0);

    run("zero_iter", 0, 16384, 1'b0, 0, 0);

    set_random(1'b0);
    rv = rnd_val();
    run("disturb", 2, rv, 1'b1, 5, 0);
    run("after_disturb", 1, rv, 1'b0, 0, 0);

    set_random(1'b1);
    rv = rnd_val();
    run("rst_abort", 3, rv, 1'b1, 0, 1 + STEP + 3);
    run("rst_clean", 3, rv, 1'b1, 0, 0);

    for (int t = 0; t < 4; t++) begin
      set_random(t[0]);
      run($sformatf("rand%0d", t), int'($urandom_range(1, 3)), rnd_val(), 1'b1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
